// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache miss-handling controller.
// Address split: index = addr[4:0], tag = addr[13:5].
package cache_ctrl_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 5;
    localparam int TAG_W  = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITEBACK,
        ST_ALLOCATE,
        ST_FILL,
        ST_DONE
    } state_e;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, cache and memory signal bundle around cache_ctrl.
// master = controller side, slave = CPU/cache/memory side.
interface cache_ctrl_if
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter int TAG_W_P  = TAG_W
);
    logic [ADDR_W_P-1:0] cpu_addr;
    logic [DATA_W_P-1:0] cpu_wr_data;
    logic                cpu_re;
    logic                cpu_we;
    logic [DATA_W_P-1:0] cpu_rd_data;
    logic                cpu_rdy;

    logic [ADDR_W_P-1:0] cache_addr;
    logic [DATA_W_P-1:0] cache_wr_data;
    logic                cache_wdirty;
    logic                cache_we;
    logic                cache_re;
    logic                cache_toggle;
    logic [DATA_W_P-1:0] cache_rd_data;
    logic [TAG_W_P-1:0]  cache_tag;
    logic                cache_hit;
    logic                cache_dirty;

    logic [ADDR_W_P-1:0] mem_addr;
    logic [DATA_W_P-1:0] mem_wr_data;
    logic                mem_re;
    logic                mem_we;
    logic [DATA_W_P-1:0] mem_rd_data;
    logic                mem_rdy;

    modport master (
        input  cpu_addr, cpu_wr_data, cpu_re, cpu_we,
        output cpu_rd_data, cpu_rdy,
        output cache_addr, cache_wr_data, cache_wdirty, cache_we, cache_re, cache_toggle,
        input  cache_rd_data, cache_tag, cache_hit, cache_dirty,
        output mem_addr, mem_wr_data, mem_re, mem_we,
        input  mem_rd_data, mem_rdy
    );

    modport slave (
        output cpu_addr, cpu_wr_data, cpu_re, cpu_we,
        input  cpu_rd_data, cpu_rdy,
        input  cache_addr, cache_wr_data, cache_wdirty, cache_we, cache_re, cache_toggle,
        output cache_rd_data, cache_tag, cache_hit, cache_dirty,
        input  mem_addr, mem_wr_data, mem_re, mem_we,
        output mem_rd_data, mem_rdy
    );

endinterface

// File: rtl/cache_ctrl_stats.sv
// Saturating probe hit/miss counters; present only with CACHE_CTRL_STATS_EN.
module cache_ctrl_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_inc,
    input  logic        miss_inc,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (miss_inc && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Miss-handling controller in front of a 2-way write-back data cache.
// Optional CACHE_CTRL_STATS_EN adds hit_cnt/miss_cnt outputs.
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | wait for cpu_re/cpu_we, latch request
// ST_COMPARE   | probe cache, decide hit / clean miss / dirty miss
// ST_WRITEBACK | write dirty victim to memory until mem_rdy
// ST_ALLOCATE  | read missing line from memory until mem_rdy
// ST_FILL      | single cache write (hit-write or miss fill)
// ST_DONE      | cpu_rdy pulse, then back to idle
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W = cache_ctrl_pkg::ADDR_W,
    parameter int DATA_W = cache_ctrl_pkg::DATA_W,
    parameter int TAG_W  = cache_ctrl_pkg::TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    cache_ctrl_if.master bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_we;
    logic              miss_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] vic_addr;
    logic [DATA_W-1:0] vic_data;
    logic [TAG_W-1:0]  vic_tag;

    assign vic_tag = bus.cache_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (bus.cpu_re || bus.cpu_we) state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (bus.cache_hit)        state_d = req_we ? ST_FILL : ST_DONE;
                else if (bus.cache_dirty) state_d = ST_WRITEBACK;
                else                      state_d = ST_ALLOCATE;
            end
            ST_WRITEBACK: if (bus.mem_rdy) state_d = ST_ALLOCATE;
            ST_ALLOCATE:  if (bus.mem_rdy) state_d = ST_FILL;
            ST_FILL:      state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // rd_data_q doubles as cpu_rd_data, so writes leave the last read value in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_data  <= '0;
            req_we    <= 1'b0;
            miss_q    <= 1'b0;
            rd_data_q <= '0;
            vic_addr  <= '0;
            vic_data  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cpu_re || bus.cpu_we) begin
                        req_addr <= bus.cpu_addr;
                        req_data <= bus.cpu_wr_data;
                        req_we   <= bus.cpu_we;
                        miss_q   <= 1'b0;
                    end
                end
                ST_COMPARE: begin
                    if (bus.cache_hit) begin
                        if (!req_we) rd_data_q <= bus.cache_rd_data;
                    end else begin
                        miss_q <= 1'b1;
                        if (bus.cache_dirty) begin
                            vic_addr <= {vic_tag, addr_idx(req_addr)};
                            vic_data <= bus.cache_rd_data;
                        end
                    end
                end
                ST_ALLOCATE: begin
                    if (bus.mem_rdy && !req_we) rd_data_q <= bus.mem_rd_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_rd_data   = rd_data_q;
    assign bus.cpu_rdy       = (state_q == ST_DONE);
    assign bus.cache_addr    = req_addr;
    assign bus.cache_wr_data = req_we ? req_data : rd_data_q;
    assign bus.cache_we      = (state_q == ST_FILL);
    assign bus.cache_wdirty  = (state_q == ST_FILL) && req_we;
    assign bus.cache_toggle  = (state_q == ST_FILL) && miss_q;
    assign bus.cache_re      = (state_q == ST_COMPARE);
    assign bus.mem_addr      = (state_q == ST_WRITEBACK) ? vic_addr : req_addr;
    assign bus.mem_wr_data   = vic_data;
    assign bus.mem_we        = (state_q == ST_WRITEBACK);
    assign bus.mem_re        = (state_q == ST_ALLOCATE);

`ifdef CACHE_CTRL_STATS_EN
    cache_ctrl_stats u_stats (
        .clk      (clk),
        .rst      (rst),
        .hit_inc  ((state_q == ST_COMPARE) && bus.cache_hit),
        .miss_inc ((state_q == ST_COMPARE) && !bus.cache_hit),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl; the bench plays CPU, cache and memory and
// predicts latency, fills and memory traffic from the transaction parameters.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if bus ();

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] last_rd = '0;
    logic [15:0] m_hits  = '0;
    logic [15:0] m_miss  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete CPU transaction, checked against predictions from its parameters.
    task automatic run_txn(input bit we, input logic [13:0] addr, input logic [63:0] wdata,
                           input bit hit, input bit dirty, input logic [8:0] tag,
                           input logic [63:0] cline, input int w_lat, input int l_lat,
                           input logic [63:0] mline);
        bit          wb       = !hit && dirty;
        int          exp_cyc  = hit ? (we ? 3 : 2) : (wb ? 3 + w_lat + l_lat : 3 + l_lat);
        logic [63:0] exp_rd   = we ? last_rd : (hit ? cline : mline);
        int          exp_fill = (hit && !we) ? 0 : 1;
        logic [13:0] vic      = {tag, addr_idx(addr)};
        int rdy_cyc = -1, n_fill = 0, n_w = 0, n_l = 0, n_probe = 0, n_both = 0, n_aerr = 0;
        logic [63:0] f_data = '0, got_rd = '0;
        logic f_wd = 1'b0, f_tg = 1'b0;
        bit done = 0;

        @(negedge clk);
        bus.cpu_addr      = addr;
        bus.cpu_wr_data   = wdata;
        bus.cpu_we        = we;
        bus.cpu_re        = we ? 1'($urandom % 2) : 1'b1;
        bus.cache_hit     = hit;
        bus.cache_dirty   = dirty;
        bus.cache_tag     = tag;
        bus.cache_rd_data = cline;
        bus.mem_rd_data   = mline;
        bus.mem_rdy       = 1'b0;
        @(posedge clk);
        #1;
        bus.cpu_re      = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = 14'($urandom);
        bus.cpu_wr_data = {$urandom, $urandom};

        for (int c = 1; c <= exp_cyc + 6 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_re && bus.mem_we) n_both++;
            if (bus.cache_re) begin
                n_probe++;
                if (bus.cache_addr !== addr) n_aerr++;
            end
            if (bus.cache_we) begin
                n_fill++;
                f_data = bus.cache_wr_data;
                f_wd   = bus.cache_wdirty;
                f_tg   = bus.cache_toggle;
                if (bus.cache_addr !== addr) n_aerr++;
            end
            if (bus.mem_we) begin
                n_w++;
                if (bus.mem_addr !== vic || bus.mem_wr_data !== cline) n_aerr++;
                bus.mem_rdy = (n_w == w_lat);
            end else if (bus.mem_re) begin
                n_l++;
                if (bus.mem_addr !== addr) n_aerr++;
                bus.mem_rdy = (n_l == l_lat);
            end else begin
                bus.mem_rdy = 1'($urandom % 2);
            end
            if (bus.cpu_rdy) begin
                done    = 1;
                rdy_cyc = c;
                got_rd  = bus.cpu_rd_data;
            end
        end
        bus.mem_rdy = 1'b0;

        chk("rdy_cycle", 64'(rdy_cyc), 64'(exp_cyc));
        chk("rd_data", got_rd, exp_rd);
        chk("probe_count", 64'(n_probe), 64'd1);
        chk("fill_count", 64'(n_fill), 64'(exp_fill));
        if (exp_fill == 1) begin
            chk("fill_data", f_data, we ? wdata : mline);
            chk("fill_wdirty", 64'(f_wd), 64'(we));
            chk("fill_toggle", 64'(f_tg), 64'(!hit));
        end
        chk("wb_cycles", 64'(n_w), wb ? 64'(w_lat) : 64'd0);
        chk("alloc_cycles", 64'(n_l), hit ? 64'd0 : 64'(l_lat));
        chk("mem_re_we_overlap", 64'(n_both), 64'd0);
        chk("addr_data_errs", 64'(n_aerr), 64'd0);

        if (!we) last_rd = exp_rd;
        if (hit) begin
            if (m_hits != 16'hFFFF) m_hits++;
        end else begin
            if (m_miss != 16'hFFFF) m_miss++;
        end
    endtask

    initial begin
        int n_seen;
        bus.cpu_addr = '0; bus.cpu_wr_data = '0; bus.cpu_re = 0; bus.cpu_we = 0;
        bus.cache_rd_data = '0; bus.cache_tag = '0; bus.cache_hit = 0; bus.cache_dirty = 0;
        bus.mem_rd_data = '0; bus.mem_rdy = 0;

        #12;
        chk("rst_cpu_rdy", 64'(bus.cpu_rdy), 64'd0);
        chk("rst_cpu_rd_data", bus.cpu_rd_data, 64'd0);
        chk("rst_strobes", {60'd0, bus.cache_we, bus.cache_re, bus.mem_re, bus.mem_we}, 64'd0);
        chk("rst_addrs", {36'd0, bus.cache_addr, bus.mem_addr}, 64'd0);
        chk("rst_wr_data", bus.cache_wr_data | bus.mem_wr_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // read hit, write hit, clean read miss, dirty miss
        run_txn(0, 14'h0021, 64'h0, 1, 0, 9'h000, 64'hA5, 1, 1, 64'h0);
        run_txn(1, 14'h0003, 64'h1234, 1, 0, 9'h000, 64'h0, 1, 1, 64'h0);
        run_txn(0, 14'h1FE5, 64'h0, 0, 0, 9'h055, 64'h99, 1, 4, 64'hDEAD);
        run_txn(0, 14'h00A5, 64'h0, 0, 1, 9'h1AB, 64'h77, 2, 3, 64'hBEEF);
        run_txn(1, 14'h3C11, 64'hCAFE, 0, 1, 9'h0F0, 64'h1111, 3, 2, 64'h2222);

        // reset during ALLOCATE must drop mem_re at once and leave no fill behind
        @(negedge clk);
        bus.cpu_addr = 14'h0444; bus.cpu_re = 1; bus.cpu_we = 0;
        bus.cache_hit = 0; bus.cache_dirty = 0; bus.mem_rdy = 0;
        @(posedge clk);
        #1 bus.cpu_re = 0;
        n_seen = 0;
        for (int c = 0; c < 10 && n_seen == 0; c++) begin
            @(negedge clk);
            if (bus.mem_re) n_seen = 1;
        end
        chk("reach_allocate", 64'(n_seen), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_mem_re", 64'(bus.mem_re), 64'd0);
        chk("rst_async_strobes", {61'd0, bus.cache_we, bus.mem_we, bus.cpu_rdy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0; m_hits = '0; m_miss = '0;
        n_seen = 0;
        for (int c = 0; c < 5; c++) begin
            bus.mem_rdy = 1'($urandom % 2);
            @(negedge clk);
            if (bus.cache_we || bus.cpu_rdy || bus.mem_re || bus.mem_we) n_seen++;
        end
        bus.mem_rdy = 0;
        chk("post_rst_idle", 64'(n_seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom % 2), 14'($urandom), {$urandom, $urandom},
                    1'($urandom % 2), 1'($urandom % 2), 9'($urandom), {$urandom, $urandom},
                    int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), {$urandom, $urandom});
        end

`ifdef CACHE_CTRL_STATS_EN
        chk("hit_cnt", 64'(hit_cnt), 64'(m_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
        @(negedge clk);
        force dut.u_stats.hit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.u_stats.hit_cnt;
        m_hits = 16'hFFFF;
        run_txn(0, 14'h0010, 64'h0, 1, 0, 9'h000, 64'h5A, 1, 1, 64'h0);
        chk("hit_cnt_sat", 64'(hit_cnt), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
